mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting directly downstream of the EX/MEM register and upstream of write-back. Resolves branches from the EX/MEM branch/zero bits and performs loads and stores on an internal word-addressed data memory with configurable access latency. Stalls upstream stages while a multi-cycle access is in flight. Registers its results into the MEM/WB boundary.

## Interface
Parameters:
- ADDR_WIDTH, 8, data memory word-address width (2^ADDR_WIDTH 32-bit words)
- MEM_LATENCY, 2, cycles per load/store, ≥1

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_ctl_in  in  2  {reg_write, mem_to_reg} from EX/MEM
- m_ctl_in  in  3  {branch, mem_read, mem_write} from EX/MEM
- add_result_in  in  32  branch target
- zero_in  in  1  ALU zero flag
- alu_result_in  in  32  ALU result / byte address
- read_data2_in  in  32  store data
- mux_out_in  in  5  destination register
- pc_src  out  1  branch taken, combinational
- branch_target  out  32  = add_result_in, combinational
- stall  out  1  hold EX/MEM and earlier stages
- align_err  out  1  misaligned-access pulse (see Configuration)
- wb_ctl_out  out  2  MEM/WB control
- read_data_out  out  32  loaded word
- alu_result_out  out  32  MEM/WB ALU result
- mux_out_out  out  5  MEM/WB destination register

## Operation
- One clock, `clk`. Reset is asynchronous and active-low on `reset_n`.
- pc_src = m_ctl_in[2] & zero_in. Branches never stall.
- mem_op = m_ctl_in[1] | m_ctl_in[0]. Word address = alu_result_in[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo memory size.
- FSM states:
  - IDLE, mem_op, MEM_LATENCY>1: go to WAIT, cnt ← MEM_LATENCY−2.
  - IDLE, otherwise: stay in IDLE.
  - WAIT, cnt≠0: cnt ← cnt−1.
  - WAIT, cnt=0: return to IDLE.
- stall = (IDLE & mem_op & MEM_LATENCY>1) | (WAIT & cnt≠0). stall is combinational from state and inputs.
- While stall=1, upstream holds all *_in inputs stable.
- Completion cycle is any cycle with stall=0. On that edge:
  - A store writes read_data2_in to mem[addr].
  - A load captures mem[addr] into read_data_out.
- mem_read and mem_write both set: the store is performed, and read_data_out gets the pre-write word (read-before-write).
- MEM/WB register on every clk edge:
  - stall=0: wb_ctl_out←wb_ctl_in, alu_result_out←alu_result_in, mux_out_out←mux_out_in. read_data_out←loaded word if mem_read, else 0.
  - stall=1: all MEM/WB outputs ← 0 (bubble). This prevents duplicate write-back.
- Memory array is not reset. Contents are undefined until written.

## Timing
- Reset values: wb_ctl_out=0, read_data_out=0, alu_result_out=0, mux_out_out=0, align_err=0, state=IDLE, cnt=0.
- While reset_n=0, stall reads 0, since FSM is IDLE and IDLE-cycle stall depends only on inputs. Upstream is also in reset.
- Reset mid-access: FSM returns to IDLE, any pending store is discarded, MEM/WB outputs clear immediately.
- Access latency: MEM_LATENCY cycles from presentation to the capturing edge. stall is high for the first MEM_LATENCY−1 of them.
- MEM_LATENCY=1: stall is never asserted, and every instruction takes 1 cycle.
- Non-memory instructions always pass through in 1 cycle.
- Back-to-back memory ops: the next op is evaluated from IDLE in the cycle after completion. There is no dead cycle.
- pc_src and branch_target are valid in the same cycle as their inputs.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A mem_op with alu_result_in[1:0]≠0 is misaligned.
  - Misaligned ops still take MEM_LATENCY cycles.
  - On completion: no memory write, read_data_out←0, wb_ctl_out←0, and align_err=1 for exactly that one registered cycle.
- MEM_ALIGN_CHECK_EN undefined:
  - alu_result_in[1:0] is ignored.
  - align_err is tied to 0.

## Test plan
- Store then load, MEM_LATENCY=2: store 0xDEADBEEF at address 0x10 with mem_write=1, then load from 0x10 with wb_ctl_in=2'b11.
  - stall=1 for 1 cycle on each op.
  - After the load's capturing edge: read_data_out=0xDEADBEEF and wb_ctl_out=2'b11.
  - During each stall cycle: wb_ctl_out=0.
- Branch: m_ctl_in=3'b100, zero_in=1, add_result_in=0x40 → pc_src=1 and branch_target=0x40 in the same cycle, no stall. With zero_in=0 → pc_src=0.
- MEM_LATENCY=4 load → stall high for exactly 3 cycles. Then an ALU op with mux_out_in=5'd7 passes in 1 cycle with mux_out_out=7.
- Reset mid-store: drop reset_n during the WAIT of a store of 0x12345678 to address 0x20.
  - Outputs clear and the FSM is IDLE.
  - After release, a load of 0x20 does not return 0x12345678 (word preloaded with 0 returns 0).
- Address wrap with ADDR_WIDTH=8: store to 0x400, then load from 0x000 → same word returned.
- With MEM_ALIGN_CHECK_EN: store to 0x13 → no write, align_err pulses for 1 cycle, wb_ctl_out=0. Without the macro: the same store writes word 4 and align_err stays 0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolve, multi-cycle data-memory access and MEM/WB register.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned loads/stores (align_err pulse).
module mem_stage #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  wb_ctl_in,
  input  logic [2:0]  m_ctl_in,
  input  logic [31:0] add_result_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] read_data2_in,
  input  logic [4:0]  mux_out_in,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        align_err,
  output logic [1:0]  wb_ctl_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  mux_out_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (MEM_LATENCY > 3) ? $clog2(MEM_LATENCY - 1) : 1;
  localparam bit MULTI = (MEM_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [31:0]            mem_q [DEPTH];

  logic                   branch, mem_read, mem_write, mem_op;
  logic                   misalign, store_en;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [31:0]            rd_word;

  logic [1:0]             wb_ctl_d,     wb_ctl_q;
  logic [31:0]            read_data_d,  read_data_q;
  logic [31:0]            alu_result_d, alu_result_q;
  logic [4:0]             mux_out_d,    mux_out_q;

  assign branch    = m_ctl_in[2];
  assign mem_read  = m_ctl_in[1];
  assign mem_write = m_ctl_in[0];
  assign mem_op    = mem_read | mem_write;
  assign addr      = alu_result_in[ADDR_WIDTH+1:2];

  assign pc_src        = branch & zero_in;
  assign branch_target = add_result_in;

  assign stall = ((state_q == S_IDLE) && mem_op && MULTI) ||
                 ((state_q == S_WAIT) && (cnt_q != '0));

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  assign misalign  = mem_op & (alu_result_in[1:0] != 2'b00);
  assign align_err = align_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) align_err_q <= 1'b0;
    else          align_err_q <= ~stall & misalign;
  end
`else
  assign misalign  = 1'b0;
  assign align_err = 1'b0;
`endif

  // Access sequencer: the first cycle is spent in IDLE, the remaining ones are counted down in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op && MULTI) begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
          else             state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Asynchronous read gives the pre-write word when a load and store share a completion edge.
  assign rd_word  = mem_q[addr];
  assign store_en = ~stall & mem_write & ~misalign;

  always_ff @(posedge clk) begin
    if (store_en) mem_q[addr] <= read_data2_in;
  end

  always_comb begin
    wb_ctl_d     = '0;
    read_data_d  = '0;
    alu_result_d = '0;
    mux_out_d    = '0;
    if (!stall) begin
      wb_ctl_d     = misalign ? 2'b00 : wb_ctl_in;
      read_data_d  = (mem_read && !misalign) ? rd_word : 32'd0;
      alu_result_d = alu_result_in;
      mux_out_d    = mux_out_in;
    end
  end

  // MEM/WB boundary: a stalled cycle inserts a bubble so write-back never sees an op twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_ctl_q     <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      mux_out_q    <= '0;
    end else begin
      wb_ctl_q     <= wb_ctl_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      mux_out_q    <= mux_out_d;
    end
  end

  assign wb_ctl_out     = wb_ctl_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign mux_out_out    = mux_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with an instruction-level reference model.
module tb_mem_stage;

  localparam int LAT = 3;
  localparam int AW  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  wb_ctl_in = '0;
  logic [2:0]  m_ctl_in = '0;
  logic [31:0] add_result_in = '0;
  logic        zero_in = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] read_data2_in = '0;
  logic [4:0]  mux_out_in = '0;
  logic        pc_src, stall, align_err;
  logic [31:0] branch_target, read_data_out, alu_result_out;
  logic [1:0]  wb_ctl_out;
  logic [4:0]  mux_out_out;

  mem_stage #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .wb_ctl_in(wb_ctl_in), .m_ctl_in(m_ctl_in),
    .add_result_in(add_result_in), .zero_in(zero_in), .alu_result_in(alu_result_in),
    .read_data2_in(read_data2_in), .mux_out_in(mux_out_in), .pc_src(pc_src),
    .branch_target(branch_target), .stall(stall), .align_err(align_err),
    .wb_ctl_out(wb_ctl_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .mux_out_out(mux_out_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Handshake between stimulus and model: each counter has exactly one writer.
  bit chk_en    = 1'b0;
  int issue_id  = 0;
  int seen_id   = 0;
  int done_id   = 0;
  int stall_seen = 0;

  // Reference model state
  logic [31:0] mm [1<<AW];
  logic [1:0]  e_wb  = '0;
  logic [31:0] e_rd  = '0;
  logic [31:0] e_alu = '0;
  logic [4:0]  e_mux = '0;
  logic        e_al  = 1'b0;

  initial begin : cmp
    int   k;
    bit   mop, mis, e_stall;
    logic [AW-1:0] idx;
    k = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        e_wb = '0; e_rd = '0; e_alu = '0; e_mux = '0; e_al = 1'b0;
      end else if (chk_en) begin
        if (seen_id != issue_id) begin
          seen_id = issue_id;
          k = 0;
          stall_seen = 0;
        end
        mop = m_ctl_in[1] | m_ctl_in[0];
`ifdef MEM_ALIGN_CHECK_EN
        mis = mop && (alu_result_in[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        e_stall = (LAT > 1) && mop && (k < LAT - 1);
        if (stall === 1'b1) stall_seen++;
        check("stall", stall, e_stall);
        check("pc_src", pc_src, m_ctl_in[2] & zero_in);
        check("branch_target", branch_target, add_result_in);
        check("wb_ctl_out", wb_ctl_out, e_wb);
        check("read_data_out", read_data_out, e_rd);
        check("alu_result_out", alu_result_out, e_alu);
        check("mux_out_out", mux_out_out, e_mux);
        check("align_err", align_err, e_al);
        if (e_stall) begin
          e_wb = '0; e_rd = '0; e_alu = '0; e_mux = '0; e_al = 1'b0;
          k++;
        end else begin
          idx   = alu_result_in[AW+1:2];
          e_rd  = (m_ctl_in[1] && !mis) ? mm[idx] : 32'd0;
          if (m_ctl_in[0] && !mis) mm[idx] = read_data2_in;
          e_wb  = mis ? 2'b00 : wb_ctl_in;
          e_alu = alu_result_in;
          e_mux = mux_out_in;
          e_al  = mis;
          done_id = seen_id;
        end
      end
    end
  end

  task automatic present(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add,
                         input logic z, input logic [31:0] alu, input logic [31:0] d,
                         input logic [4:0] mx);
    wb_ctl_in = wb; m_ctl_in = m; add_result_in = add; zero_in = z;
    alu_result_in = alu; read_data2_in = d; mux_out_in = mx;
    issue_id++;
  endtask

  task automatic finish_instr();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (done_id != issue_id && n < LAT + 3);
    if (done_id != issue_id) begin
      total++; bad++;
      $display("FAIL timeout cycles=%0d limit=%0d", n, LAT + 3);
    end
    #1;
  endtask

  task automatic op(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                    input logic [31:0] d, input logic [4:0] mx);
    present(wb, m, $urandom, 1'b0, alu, d, mx);
    finish_instr();
  endtask

  initial begin : main
    logic [31:0] a, hi, v;
    int idx, lo, sel;

    @(posedge clk); #1;
    check("rst_wb", wb_ctl_out, 0);
    check("rst_rd", read_data_out, 0);
    check("rst_alu", alu_result_out, 0);
    check("rst_mux", mux_out_out, 0);
    check("rst_stall", stall, 0);
    check("rst_align", align_err, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      v = (i == 8) ? 32'd0 : $urandom;
      op(2'b00, 3'b001, i << 2, v, 5'd0);
    end

    op(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
    check("store_stall_cycles", stall_seen, LAT - 1);
    op(2'b11, 3'b010, 32'h10, 32'h0, 5'd3);
    check("load_stall_cycles", stall_seen, LAT - 1);
    check("load_data", read_data_out, 32'hDEADBEEF);
    check("load_wb", wb_ctl_out, 2'b11);
    check("load_mux", mux_out_out, 5'd3);

    op(2'b10, 3'b000, 32'h1234, 32'h0, 5'd7);
    check("alu_stall_cycles", stall_seen, 0);
    check("alu_mux", mux_out_out, 5'd7);
    check("alu_result", alu_result_out, 32'h1234);
    check("alu_rd_zero", read_data_out, 0);

    present(2'b00, 3'b100, 32'h40, 1'b1, 32'h0, 32'h0, 5'd0);
    #2;
    check("br_taken", pc_src, 1'b1);
    check("br_target", branch_target, 32'h40);
    check("br_nostall", stall, 1'b0);
    finish_instr();
    present(2'b00, 3'b100, 32'h80, 1'b0, 32'h0, 32'h0, 5'd0);
    #2;
    check("br_not_taken", pc_src, 1'b0);
    finish_instr();

    op(2'b00, 3'b001, 32'h400, 32'hCAFEF00D, 5'd0);
    op(2'b10, 3'b010, 32'h000, 32'h0, 5'd1);
    check("wrap_load", read_data_out, 32'hCAFEF00D);

    op(2'b00, 3'b001, 32'h14, 32'h11111111, 5'd0);
    op(2'b10, 3'b011, 32'h14, 32'h22222222, 5'd2);
    check("rbw_old", read_data_out, 32'h11111111);
    op(2'b10, 3'b010, 32'h14, 32'h0, 5'd2);
    check("rbw_new", read_data_out, 32'h22222222);

    op(2'b10, 3'b001, 32'h13, 32'h55AA55AA, 5'd4);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_align_err", align_err, 1'b1);
    check("mis_wb", wb_ctl_out, 2'b00);
`else
    check("mis_align_err", align_err, 1'b0);
    check("mis_wb", wb_ctl_out, 2'b10);
`endif
    op(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    check("align_err_pulse_end", align_err, 1'b0);
    op(2'b10, 3'b010, 32'h10, 32'h0, 5'd4);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_nowrite", read_data_out, 32'hDEADBEEF);
`else
    check("mis_write", read_data_out, 32'h55AA55AA);
`endif

    // Reset in the middle of a store to word 8
    present(2'b00, 3'b001, 32'h0, 1'b0, 32'h20, 32'h12345678, 5'd0);
    @(posedge clk); #1;
    chk_en = 1'b0;
    #1;
    reset_n = 1'b0;
    wb_ctl_in = '0; m_ctl_in = '0; add_result_in = '0; zero_in = 1'b0;
    alu_result_in = '0; read_data2_in = '0; mux_out_in = '0;
    #1;
    check("mrst_stall", stall, 0);
    check("mrst_wb", wb_ctl_out, 0);
    check("mrst_rd", read_data_out, 0);
    check("mrst_alu", alu_result_out, 0);
    check("mrst_mux", mux_out_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    op(2'b11, 3'b010, 32'h20, 32'h0, 5'd9);
    check("mrst_load_stall", stall_seen, LAT - 1);
    check("mrst_discard", read_data_out, 32'd0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      hi  = $urandom;
      idx = $urandom_range(0, 15);
      lo  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      a   = (hi & 32'hFFFF_FC00) | (idx << 2) | lo;
      case (sel)
        0, 1, 2: present(2'($urandom), 3'b000, $urandom, 1'($urandom), $urandom, $urandom, 5'($urandom));
        3, 4:    present(2'($urandom), 3'b100, $urandom, 1'($urandom), $urandom, $urandom, 5'($urandom));
        5, 6:    present(2'($urandom), 3'b010, $urandom, 1'b0, a, $urandom, 5'($urandom));
        7, 8:    present(2'($urandom), 3'b001, $urandom, 1'b0, a, $urandom, 5'($urandom));
        default: present(2'($urandom), 3'b011, $urandom, 1'b0, a, $urandom, 5'($urandom));
      endcase
      finish_instr();
    end

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
